// File: rtl/tok_buf_pkg.sv
// Shared types and constants for the token buffer and its arbiter.
package tok_buf_pkg;

  typedef enum logic {StIdle, StClear} tok_state_e;

  localparam int unsigned DefNumCh     = 4;
  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefDataWidth = 64;

  function automatic int unsigned ch_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last advanced grant.
module rr_arbiter
  import tok_buf_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned IdxW = ch_idx_width(N);

  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned cand;
    logic        found;
    cand    = 0;
    found   = 1'b0;
    grant_o = '0;
    ptr_d   = ptr_q;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr_q) + i) % N;
      if (!found && req_i[IdxW'(cand)]) begin
        found                 = 1'b1;
        grant_o[IdxW'(cand)]  = 1'b1;
        if (advance_i) begin
          ptr_d = IdxW'((cand + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram16_wrapper.sv
// Single-port synchronous SRAM: write on load_en, registered read on fetch_en.
module sram16_wrapper #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  load_en_i,
  input  logic                  fetch_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (load_en_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (fetch_en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/token_buffer_arb.sv
// Multi-channel token SRAM with round-robin request arbitration, routed read
// responses and a hardware clear sweep.
module token_buffer_arb
  import tok_buf_pkg::*;
#(
  parameter int unsigned NUM_CH     = DefNumCh,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              req_valid_i,
  output logic [NUM_CH-1:0]              req_ready_o,
  input  logic [NUM_CH-1:0]              req_we_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   req_wdata_i,
  output logic [NUM_CH-1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
  input  logic                           clear_start_i,
  output logic                           busy_o,
  output logic                           clear_done_o
);

  localparam int unsigned ChW = ch_idx_width(NUM_CH);
  localparam logic [NUM_CH-1:0] ChOne = NUM_CH'(1);

  tok_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  clr_last_q, clr_last_d;
  logic                  clear_done_q, clear_done_d;

  logic [NUM_CH-1:0]     grant;
  logic                  grant_en;
  logic                  accept;
  logic [ChW-1:0]        acc_idx;

  logic                  s1_valid_q, s1_we_q;
  logic [ChW-1:0]        s1_ch_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic [DATA_WIDTH-1:0] s1_wdata_q;
  logic                  s2_rd_q;
  logic [ChW-1:0]        s2_ch_q;
  logic [NUM_CH-1:0]     rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic                  clearing;
  logic                  sram_load;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata, sram_rdata;

  rr_arbiter #(
    .N(NUM_CH)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid_i),
    .advance_i (accept),
    .grant_o   (grant)
  );

  // rst_n gates ready so nothing is granted while the design is held in reset.
  assign grant_en    = rst_n && (state_q == StIdle) && !clear_start_i;
  assign req_ready_o = grant & {NUM_CH{grant_en}};
  assign accept      = |(req_valid_i & req_ready_o);

  always_comb begin
    acc_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (req_ready_o[i]) acc_idx = ChW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clr_last_d   = clr_last_q;
    clear_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_start_i) begin
          state_d    = StClear;
          clr_addr_d = '0;
          clr_last_d = 1'b0;
        end
      end
      StClear: begin
        // One extra cycle after the final write so done lines up with busy falling.
        if (clr_last_q) begin
          state_d      = StIdle;
          clear_done_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
          if (clr_addr_q == {ADDR_WIDTH{1'b1}}) clr_last_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      clr_addr_q   <= '0;
      clr_last_q   <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_last_q   <= clr_last_d;
      clear_done_q <= clear_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_we_q     <= 1'b0;
      s1_ch_q     <= '0;
      s1_addr_q   <= '0;
      s1_wdata_q  <= '0;
      s2_rd_q     <= 1'b0;
      s2_ch_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_ch_q    <= acc_idx;
        s1_we_q    <= req_we_i[acc_idx];
        s1_addr_q  <= req_addr_i[acc_idx*ADDR_WIDTH +: ADDR_WIDTH];
        s1_wdata_q <= req_wdata_i[acc_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      s2_rd_q     <= s1_valid_q & ~s1_we_q;
      s2_ch_q     <= s1_ch_q;
      rsp_valid_q <= s2_rd_q ? (ChOne << s2_ch_q) : '0;
      if (s2_rd_q) rsp_rdata_q <= sram_rdata;
    end
  end

  assign clearing   = (state_q == StClear);
  assign sram_load  = clearing ? !clr_last_q : (s1_valid_q & s1_we_q);
  assign sram_addr  = clearing ? clr_addr_q : s1_addr_q;
  assign sram_wdata = clearing ? '0 : s1_wdata_q;

  sram16_wrapper #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sram (
    .clk        (clk),
    .load_en_i  (sram_load),
    .fetch_en_i (1'b1),
    .addr_i     (sram_addr),
    .wdata_i    (sram_wdata),
    .rdata_o    (sram_rdata)
  );

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign busy_o       = clearing;
  assign clear_done_o = clear_done_q;

endmodule

// File: tb/tb_token_buffer_arb.sv
// Directed plus random bench for token_buffer_arb against a transaction-level model.
module tb_token_buffer_arb;

  localparam int NCh = 4;
  localparam int Aw  = 8;
  localparam int Dw  = 64;
  localparam int Dep = 256;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCh-1:0]   req_valid, req_ready, req_we, rsp_valid;
  logic [NCh*Aw-1:0] req_addr;
  logic [NCh*Dw-1:0] req_wdata;
  logic [Dw-1:0]    rsp_rdata;
  logic             clear_start, busy, clear_done;

  token_buffer_arb #(
    .NUM_CH(NCh), .ADDR_WIDTH(Aw), .DATA_WIDTH(Dw)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .clear_start_i (clear_start),
    .busy_o        (busy),
    .clear_done_o  (clear_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [63:0] data;
    bit          known;
    int          due;
  } rsp_t;

  // Transaction-level model state
  logic [63:0] mem_m [Dep];
  bit          known_m [Dep];
  rsp_t        pend[$];
  int          start_m, cyc, clr_cnt;
  bit          busy_m, done_m;

  int errors = 0;
  int checks = 0;
  int busy_cnt, done_cnt;
  logic [NCh-1:0] obs_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    if (busy_m) foreach (known_m[i]) known_m[i] = 1'b0;
    pend.delete();
    start_m = 0;
    busy_m  = 1'b0;
    done_m  = 1'b0;
  endtask

  function automatic logic [NCh-1:0] exp_ready();
    if (!rst_n || busy_m || clear_start) return '0;
    for (int i = 0; i < NCh; i++) begin
      int c;
      c = (start_m + i) % NCh;
      if (req_valid[c]) return NCh'(1) << c;
    end
    return '0;
  endfunction

  task automatic model_edge(input logic [NCh-1:0] er);
    cyc++;
    done_m = 1'b0;
    if (busy_m) begin
      if (clr_cnt < Dep) begin
        mem_m[clr_cnt]   = '0;
        known_m[clr_cnt] = 1'b1;
        clr_cnt++;
      end else begin
        busy_m = 1'b0;
        done_m = 1'b1;
      end
    end else if (clear_start) begin
      busy_m  = 1'b1;
      clr_cnt = 0;
    end else if (er != '0) begin
      for (int c = 0; c < NCh; c++) begin
        if (er[c]) begin
          int a;
          a = int'(req_addr[c*Aw +: Aw]);
          if (req_we[c]) begin
            mem_m[a]   = req_wdata[c*Dw +: Dw];
            known_m[a] = 1'b1;
          end else begin
            pend.push_back('{ch: c, data: mem_m[a], known: known_m[a], due: cyc + 2});
          end
          start_m = (c + 1) % NCh;
        end
      end
    end
  endtask

  task automatic tick();
    logic [NCh-1:0] er, ev;
    @(negedge clk);
    if (!rst_n) model_reset();
    er = exp_ready();
    obs_ready = req_ready;
    chk("req_ready", req_ready, er);
    ev = '0;
    if (pend.size() > 0 && pend[0].due == cyc) ev = NCh'(1) << pend[0].ch;
    chk("rsp_valid", rsp_valid, ev);
    if (ev != '0) begin
      if (pend[0].known) chk("rsp_rdata", rsp_rdata, pend[0].data);
      void'(pend.pop_front());
    end
    chk("busy", busy, busy_m);
    chk("clear_done", clear_done, done_m);
    busy_cnt += int'(busy);
    done_cnt += int'(clear_done);
    @(posedge clk);
    if (rst_n) model_edge(er);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; clear_start = 1'b0;
  endtask

  task automatic set_req(input int ch, input bit we, input logic [7:0] a, input logic [63:0] d);
    req_valid[ch]         = 1'b1;
    req_we[ch]            = we;
    req_addr[ch*Aw +: Aw] = a;
    req_wdata[ch*Dw +: Dw] = d;
  endtask

  initial begin
    foreach (known_m[i]) begin known_m[i] = 1'b0; mem_m[i] = '0; end
    cyc = 0; clr_cnt = 0; busy_m = 0; done_m = 0; start_m = 0;
    busy_cnt = 0; done_cnt = 0;
    idle_inputs();
    rst_n = 1'b0;
    req_valid = '1;

    // Reset: everything quiet even with all channels requesting
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_rdata", rsp_rdata, 64'h0);
    end
    rst_n = 1'b1;
    idle_inputs();
    tick();

    // Single channel write then read-after-write
    set_req(2, 1, 8'h10, 64'hDEAD_BEEF_0000_0001);
    tick();
    idle_inputs();
    set_req(2, 0, 8'h10, 64'h0);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();

    // Preload 0..3 through ch3 so the pointer returns to channel 0
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      set_req(3, 1, 8'(i), 64'hC0DE_0000_0000_0000 | 64'(i));
      tick();
    end
    idle_inputs();

    // Contention: all channels reading their own address
    for (int c = 0; c < NCh; c++) set_req(c, 0, 8'(c), 64'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("grant_order", obs_ready, 64'(NCh'(1) << (k % NCh)));
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();

    // Random traffic over a small address window
    for (int k = 0; k < 300; k++) begin
      idle_inputs();
      for (int c = 0; c < NCh; c++) begin
        if ($urandom_range(0, 2) != 0)
          set_req(c, bit'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                  {$urandom, $urandom});
      end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();

    // Clear sweep with requests pending throughout
    set_req(1, 1, 8'hFF, 64'h1234);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) tick();
    clear_start = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    tick();
    clear_start = 1'b0;
    for (int c = 0; c < NCh; c++) set_req(c, 0, 8'hFF, 64'h0);
    req_valid = '0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 262; i++) tick();
    chk("busy_cycles", 64'(busy_cnt), 64'(Dep + 1));
    chk("done_pulses", 64'(done_cnt), 64'd1);
    idle_inputs();
    set_req(3, 0, 8'hFF, 64'h0);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();

    // Clear right after a read is accepted: read sees pre-clear data
    set_req(0, 1, 8'h05, 64'hAA);
    tick();
    idle_inputs();
    set_req(0, 0, 8'h05, 64'h0);
    tick();
    idle_inputs();
    clear_start = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 262; i++) tick();
    chk("done_pulses2", 64'(done_cnt), 64'd1);

    // Reset in the middle of a sweep
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 16'h40; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("busy_async_rst", busy, 1'b0);
    done_cnt = 0;
    tick();
    tick();
    rst_n = 1'b1;
    set_req(1, 1, 8'h20, 64'h5555_AAAA);
    tick();
    idle_inputs();
    set_req(2, 0, 8'h20, 64'h0);
    tick();
    idle_inputs();
    for (int i = 0; i < 300; i++) tick();
    chk("no_done_after_abort", 64'(done_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
